// File: rtl/mmcm_drp_reconfig.sv
`default_nettype none
// ============================================================================
// mmcm_drp_reconfig
// DRP read-modify-write sequencer for run-time MMCME2/PLLE2 reconfiguration.
// Rev 1.0
// ============================================================================
module mmcm_drp_reconfig #(
  parameter int RST_HOLD     = 16,
  parameter int DRDY_TIMEOUT = 255,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [6:0]  cfg_addr,
  input  logic [15:0] cfg_mask,
  input  logic [15:0] cfg_data,
  input  logic        cfg_last,
  output logic [6:0]  daddr,
  output logic [15:0] di,
  output logic        den,
  output logic        dwe,
  input  logic [15:0] do_in,
  input  logic        drdy,
  output logic        mmcm_rst,
  input  logic        mmcm_locked,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam int DRDY_W = $clog2(DRDY_TIMEOUT + 1);
  localparam int LOCK_W = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(RST_HOLD - 1);
  localparam logic [HOLD_W-1:0] c_hold_one  = HOLD_W'(1);
  localparam logic [DRDY_W-1:0] c_drdy_max  = DRDY_W'(DRDY_TIMEOUT);
  localparam logic [DRDY_W-1:0] c_drdy_one  = DRDY_W'(1);
  localparam logic [LOCK_W-1:0] c_lock_max  = LOCK_W'(LOCK_TIMEOUT);
  localparam logic [LOCK_W-1:0] c_lock_one  = LOCK_W'(1);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    HOLD_RST   = 4'd1,
    WAIT_ENTRY = 4'd2,
    RD_REQ     = 4'd3,
    RD_WAIT    = 4'd4,
    WR_REQ     = 4'd5,
    WR_WAIT    = 4'd6,
    RELEASE    = 4'd7,
    WAIT_LOCK  = 4'd8,
    FINISH     = 4'd9
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_lock_meta;
  logic              r_lock_s;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [DRDY_W-1:0] r_drdy_cnt;
  logic [LOCK_W-1:0] r_lock_cnt;
  logic [6:0]        r_addr;
  logic [15:0]       r_mask;
  logic [15:0]       r_data;
  logic              r_last;
  logic [15:0]       r_wdata;
  logic              r_rst;
  logic              r_err;
  logic              w_hold_done;
  logic              w_drdy_to;
  logic              w_lock_to;
  logic              w_rst_nxt;

  // Timeout counters hold "cycles since den/release"; the wait states exit
  // at the maximum, so the increment below can never wrap.
  assign w_hold_done = (r_hold_cnt == c_hold_last);
  assign w_drdy_to   = (r_drdy_cnt >= c_drdy_max);
  assign w_lock_to   = (r_lock_cnt >= c_lock_max);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:       if (cfg_valid) w_state_nxt = HOLD_RST;
      HOLD_RST:   if (w_hold_done) w_state_nxt = WAIT_ENTRY;
      WAIT_ENTRY: if (cfg_valid) w_state_nxt = RD_REQ;
      RD_REQ:     w_state_nxt = RD_WAIT;
      RD_WAIT: begin
        if (drdy)           w_state_nxt = WR_REQ;
        else if (w_drdy_to) w_state_nxt = FINISH;
      end
      WR_REQ:     w_state_nxt = WR_WAIT;
      WR_WAIT: begin
        if (drdy)           w_state_nxt = r_last ? RELEASE : WAIT_ENTRY;
        else if (w_drdy_to) w_state_nxt = FINISH;
      end
      RELEASE:    w_state_nxt = WAIT_LOCK;
      WAIT_LOCK:  if (r_lock_s || w_lock_to) w_state_nxt = FINISH;
      FINISH:     w_state_nxt = IDLE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  // Primitive RST is registered from the next-state decode so it never glitches.
  always_comb begin
    w_rst_nxt = 1'b0;
    case (w_state_nxt)
      HOLD_RST, WAIT_ENTRY, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT: w_rst_nxt = 1'b1;
      default: w_rst_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
      r_hold_cnt  <= '0;
      r_drdy_cnt  <= '0;
      r_lock_cnt  <= '0;
      r_addr      <= '0;
      r_mask      <= '0;
      r_data      <= '0;
      r_last      <= 1'b0;
      r_wdata     <= '0;
      r_rst       <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lock_meta <= mmcm_locked;
      r_lock_s    <= r_lock_meta;
      r_rst       <= w_rst_nxt;
      case (r_state)
        IDLE: begin
          r_hold_cnt <= '0;
          if (cfg_valid) r_err <= 1'b0;
        end
        HOLD_RST: if (!w_hold_done) r_hold_cnt <= r_hold_cnt + c_hold_one;
        WAIT_ENTRY: begin
          if (cfg_valid) begin
            r_addr <= cfg_addr;
            r_mask <= cfg_mask;
            r_data <= cfg_data;
            r_last <= cfg_last;
          end
        end
        RD_REQ, WR_REQ: r_drdy_cnt <= c_drdy_one;
        RD_WAIT: begin
          if (drdy)           r_wdata    <= (do_in & r_mask) | (r_data & ~r_mask);
          else if (w_drdy_to) r_err      <= 1'b1;
          else                r_drdy_cnt <= r_drdy_cnt + c_drdy_one;
        end
        WR_WAIT: begin
          if (!drdy) begin
            if (w_drdy_to) r_err      <= 1'b1;
            else           r_drdy_cnt <= r_drdy_cnt + c_drdy_one;
          end
        end
        RELEASE: r_lock_cnt <= c_lock_one;
        WAIT_LOCK: begin
          if (!r_lock_s) begin
            if (w_lock_to) r_err      <= 1'b1;
            else           r_lock_cnt <= r_lock_cnt + c_lock_one;
          end
        end
        default: ;
      endcase
    end
  end

  assign cfg_ready = (r_state == WAIT_ENTRY);
  assign den       = (r_state == RD_REQ) || (r_state == WR_REQ);
  assign dwe       = (r_state == WR_REQ);
  assign daddr     = r_addr;
  assign di        = r_wdata;
  assign mmcm_rst  = r_rst;
  assign busy      = (r_state != IDLE) && (r_state != FINISH);
  assign done      = (r_state == FINISH);
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mmcm_drp_reconfig.sv
`default_nettype none
// tb_mmcm_drp_reconfig: scoreboard bench with DRP slave and LOCKED models.
module tb_mmcm_drp_reconfig;

  localparam int RST_HOLD     = 16;
  localparam int DRDY_TIMEOUT = 255;
  localparam int LOCK_TIMEOUT = 100;
  localparam int LOCK_DELAY   = 50;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [6:0]  cfg_addr;
  logic [15:0] cfg_mask;
  logic [15:0] cfg_data;
  logic        cfg_last;
  logic [6:0]  daddr;
  logic [15:0] di;
  logic        den;
  logic        dwe;
  logic [15:0] do_in;
  logic        drdy;
  logic        mmcm_rst;
  logic        mmcm_locked;
  logic        busy;
  logic        done;
  logic        err;

  logic drp_drdy, stray_drdy;
  assign drdy = drp_drdy | stray_drdy;

  mmcm_drp_reconfig #(
    .RST_HOLD    (RST_HOLD),
    .DRDY_TIMEOUT(DRDY_TIMEOUT),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_addr   (cfg_addr),
    .cfg_mask   (cfg_mask),
    .cfg_data   (cfg_data),
    .cfg_last   (cfg_last),
    .daddr      (daddr),
    .di         (di),
    .den        (den),
    .dwe        (dwe),
    .do_in      (do_in),
    .drdy       (drdy),
    .mmcm_rst   (mmcm_rst),
    .mmcm_locked(mmcm_locked),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed { logic we; logic [6:0] addr; logic [15:0] di; } drp_t;
  typedef struct { logic err; int kind; int lo; int hi; } done_t;

  drp_t  q_drp[$];
  done_t q_done[$];

  int checks = 0, failures = 0;
  int cyc = 0, done_cnt = 0, rst_falls = 0;
  int rst_rise_cyc = 0, rst_fall_cyc = 0, lock_rise_cyc = 0, den_cyc = 0;
  logic prev_rst = 1'b0, prev_lock = 1'b0, first_den = 1'b0;
  logic hang_rd = 1'b0, hang_wr = 1'b0, lock_en = 1'b1;
  int drp_lat = 1;

  task automatic chk(input logic ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_rd(input logic [6:0] a);
    q_drp.push_back({1'b0, a, 16'h0000});
  endtask
  task automatic push_wr(input logic [6:0] a, input logic [15:0] d);
    q_drp.push_back({1'b1, a, d});
  endtask
  // kind: 0 = from locked rise, 1 = from last den, 2 = from mmcm_rst release
  task automatic push_done(input logic e, input int kind, input int lo, input int hi);
    done_t t;
    t.err = e; t.kind = kind; t.lo = lo; t.hi = hi;
    q_done.push_back(t);
  endtask

  // Fixed register image returned on reads; writes do not alter it.
  function automatic logic [15:0] rom(input logic [6:0] a);
    case (a)
      7'h08:   rom = 16'h1041;
      7'h09:   rom = 16'h8A5A;
      7'h14:   rom = 16'hFFFF;
      default: rom = 16'h0000;
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // DRP slave
  initial begin
    logic rd;
    logic [6:0] a;
    drp_drdy = 1'b0;
    do_in    = 16'h0;
    forever begin
      @(negedge clk);
      if (reset_n && den && !((dwe && hang_wr) || (!dwe && hang_rd))) begin
        rd = !dwe;
        a  = daddr;
        repeat (drp_lat) @(posedge clk);
        #1;
        drp_drdy = 1'b1;
        do_in    = rd ? rom(a) : 16'h0;
        @(posedge clk);
        #1;
        drp_drdy = 1'b0;
        do_in    = 16'h0;
      end
    end
  end

  // LOCKED model
  initial begin
    int lk;
    lk = 0;
    mmcm_locked = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mmcm_rst || !lock_en) begin
        mmcm_locked = 1'b0;
        lk = 0;
      end else if (lk < LOCK_DELAY) begin
        lk++;
        if (lk == LOCK_DELAY) mmcm_locked = 1'b1;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    drp_t  e;
    done_t de;
    int    rcyc;
    forever begin
      @(negedge clk);
      if (mmcm_rst && !prev_rst) begin
        rst_rise_cyc = cyc;
        first_den = 1'b1;
      end
      if (!mmcm_rst && prev_rst) begin
        rst_fall_cyc = cyc;
        rst_falls++;
        chk(q_drp.size() == 0, "rst_fall_after_last_access", q_drp.size(), 0);
      end
      if (mmcm_locked && !prev_lock) lock_rise_cyc = cyc;
      prev_rst  = mmcm_rst;
      prev_lock = mmcm_locked;
      if (reset_n) begin
        if (cfg_ready) chk(mmcm_rst && busy && !den, "ready_state", {mmcm_rst, busy, den}, 3'b110);
        if (den) begin
          den_cyc = cyc;
          if (first_den) chk(cyc - rst_rise_cyc >= RST_HOLD, "rst_hold", cyc - rst_rise_cyc, RST_HOLD);
          first_den = 1'b0;
          chk(q_drp.size() != 0, "drp_expected", {dwe, daddr}, 1);
          if (q_drp.size() != 0) begin
            e = q_drp.pop_front();
            chk(dwe == e.we, "drp_we", dwe, e.we);
            chk(daddr == e.addr, "drp_addr", daddr, e.addr);
            if (e.we) chk(di == e.di, "drp_di", di, e.di);
          end
        end
        if (done) begin
          done_cnt++;
          chk(q_done.size() != 0, "done_expected", q_done.size(), 1);
          if (q_done.size() != 0) begin
            de = q_done.pop_front();
            rcyc = (de.kind == 0) ? lock_rise_cyc : (de.kind == 1) ? den_cyc : rst_fall_cyc;
            chk(err == de.err, "done_err", err, de.err);
            chk((cyc - rcyc >= de.lo) && (cyc - rcyc <= de.hi), "done_latency", cyc - rcyc, de.lo);
            chk(q_drp.size() == 0, "drp_all_seen", q_drp.size(), 0);
          end
        end
      end
    end
  end

  task automatic send_entry(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d,
                            input logic l);
    int   n;
    logic hs;
    n = 0;
    hs = 1'b0;
    cfg_addr = a; cfg_mask = m; cfg_data = d; cfg_last = l;
    cfg_valid = 1'b1;
    while (!hs && n < 1000) begin
      @(negedge clk);
      hs = cfg_ready;
      n++;
      @(posedge clk);
      #1;
    end
    cfg_valid = 1'b0;
    chk(hs, "cfg_handshake", hs, 1);
  endtask

  task automatic wait_done(input int base);
    int n;
    n = 0;
    while (done_cnt == base && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(done_cnt != base, "done_timeout", n, 1000);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_stray;
    @(posedge clk); #1; stray_drdy = 1'b1;
    @(posedge clk); #1; stray_drdy = 1'b0;
  endtask

  initial begin
    int   base, falls0, n;
    logic seen;
    reset_n = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_mask = '0; cfg_data = '0;
    cfg_last = 1'b0; stray_drdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk({cfg_ready, den, dwe, mmcm_rst, busy, done, err} == 7'b0, "reset_ctrl",
        {cfg_ready, den, dwe, mmcm_rst, busy, done, err}, 0);
    chk({daddr, di} == 23'b0, "reset_drp_bus", {daddr, di}, 0);
    reset_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;

    // Single entry: 0x1041 keep bit 12, rest from 0x0186 -> 0x1186
    drp_lat = 1;
    push_rd(7'h08); push_wr(7'h08, 16'h1186); push_done(1'b0, 0, 3, 3);
    base = done_cnt;
    send_entry(7'h08, 16'h1000, 16'h0186, 1'b1);
    wait_done(base);
    chk(err == 1'b0, "single_err", err, 0);

    // Three entries with gaps; mmcm_rst must stay high throughout
    drp_lat = 3;
    falls0 = rst_falls;
    push_rd(7'h08); push_wr(7'h08, 16'h10C3);
    push_rd(7'h09); push_wr(7'h09, 16'h9234);
    push_rd(7'h14); push_wr(7'h14, 16'h1F0F);
    push_done(1'b0, 0, 3, 3);
    base = done_cnt;
    send_entry(7'h08, 16'hFF00, 16'h00C3, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk(mmcm_rst == 1'b1, "rst_gap1", mmcm_rst, 1);
    send_entry(7'h09, 16'h8000, 16'h1234, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk(mmcm_rst == 1'b1, "rst_gap2", mmcm_rst, 1);
    send_entry(7'h14, 16'h0F0F, 16'h1200, 1'b1);
    wait_done(base);
    chk(rst_falls - falls0 == 1, "rst_single_release", rst_falls - falls0, 1);

    // DRDY timeout on the first read
    drp_lat = 1;
    hang_rd = 1'b1;
    push_rd(7'h09); push_done(1'b1, 1, DRDY_TIMEOUT + 1, DRDY_TIMEOUT + 3);
    base = done_cnt;
    send_entry(7'h09, 16'h0000, 16'hABCD, 1'b0);
    wait_done(base);
    hang_rd = 1'b0;
    chk(err == 1'b1, "drdy_to_err", err, 1);
    chk(mmcm_rst == 1'b0, "drdy_to_rst", mmcm_rst, 0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | cfg_ready;
    end
    chk(!seen, "drdy_to_no_ready", seen, 0);
    push_rd(7'h14); push_wr(7'h14, 16'h55FF); push_done(1'b0, 0, 3, 3);
    base = done_cnt;
    @(posedge clk); #1;
    send_entry(7'h14, 16'h00FF, 16'h5500, 1'b1);
    wait_done(base);
    chk(err == 1'b0, "err_cleared", err, 0);

    // LOCK timeout
    lock_en = 1'b0;
    push_rd(7'h08); push_wr(7'h08, 16'h1041); push_done(1'b1, 2, LOCK_TIMEOUT, LOCK_TIMEOUT + 2);
    base = done_cnt;
    @(posedge clk); #1;
    send_entry(7'h08, 16'hFFFF, 16'h0000, 1'b1);
    wait_done(base);
    lock_en = 1'b1;
    chk(err == 1'b1, "lock_to_err", err, 1);

    // Reset during WR_WAIT
    hang_wr = 1'b1;
    push_rd(7'h09); push_wr(7'h09, 16'h0F0F);
    base = done_cnt;
    @(posedge clk); #1;
    send_entry(7'h09, 16'h0000, 16'h0F0F, 1'b1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 500) begin
      @(negedge clk);
      seen = den && dwe;
      n++;
    end
    chk(seen, "write_issued", seen, 1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk({den, dwe, mmcm_rst, busy, done, cfg_ready} == 6'b0, "async_reset",
        {den, dwe, mmcm_rst, busy, done, cfg_ready}, 0);
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    hang_wr = 1'b0;
    repeat (20) @(negedge clk);
    chk(busy == 1'b0, "reset_idle", busy, 0);
    chk(done_cnt == base, "no_spurious_done", done_cnt, base);
    push_rd(7'h08); push_wr(7'h08, 16'h4321); push_done(1'b0, 0, 3, 3);
    @(posedge clk); #1;
    send_entry(7'h08, 16'h0000, 16'h4321, 1'b1);
    wait_done(base);

    // Stray drdy in IDLE and WAIT_ENTRY
    pulse_stray();
    repeat (3) @(negedge clk);
    chk({busy, mmcm_rst} == 2'b00, "stray_idle", {busy, mmcm_rst}, 0);
    @(posedge clk); #1; cfg_valid = 1'b1;
    @(posedge clk); #1; cfg_valid = 1'b0;
    n = 0;
    while (!cfg_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(cfg_ready == 1'b1, "wait_entry_reached", cfg_ready, 1);
    pulse_stray();
    repeat (5) @(negedge clk);
    chk(cfg_ready == 1'b1, "stray_wait_entry", cfg_ready, 1);
    push_rd(7'h14); push_wr(7'h14, 16'hFABC); push_done(1'b0, 0, 3, 3);
    base = done_cnt;
    @(posedge clk); #1;
    send_entry(7'h14, 16'hF000, 16'h0ABC, 1'b1);
    wait_done(base);

    chk(q_drp.size() + q_done.size() == 0, "queues_drained", q_drp.size() + q_done.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/mmcm_drp_reconfig.md
Name: mmcm_drp_reconfig

Overview:
- DRP initiator that rewrites MMCME2_ADV / PLLE2_ADV clock registers at run time. Frequencies and phases can then change without rebuilding the fixed clock-generation wrapper.
- Accepts a stream of (address, mask, data) entries and sequences the primitive through: assert RST, read-modify-write each register, release RST, wait for LOCKED.
- Sits beside the clock wrapper. Drives the DCLK-domain DRP port, RST and LOCKED that the wrapper otherwise ties off.

Parameters:
- RST_HOLD, 16: cycles mmcm_rst stays high before the first DRP access (≥1).
- DRDY_TIMEOUT, 255: maximum cycles from den to drdy before error.
- LOCK_TIMEOUT, 65535: maximum cycles from mmcm_rst release to synchronised locked before error.

Ports:
- clk  input  1  system clock; also the primitive's DCLK.
- reset_n  input  1  asynchronous active-low reset.
- cfg_valid  input  1  entry valid.
- cfg_ready  output  1  block accepts entry.
- cfg_addr  input  7  DRP register address.
- cfg_mask  input  16  1 = keep the existing bit.
- cfg_data  input  16  new bit values where mask = 0.
- cfg_last  input  1  final entry of the configuration.
- daddr  output  7  DRP address.
- di  output  16  DRP write data.
- den  output  1  DRP enable.
- dwe  output  1  DRP write enable.
- do_in  input  16  DRP read data.
- drdy  input  1  DRP ready.
- mmcm_rst  output  1  primitive RST.
- mmcm_locked  input  1  primitive LOCKED (asynchronous).
- busy  output  1  sequence in progress.
- done  output  1  one-cycle completion pulse.
- err  output  1  sticky error flag.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, counters cleared. This includes mmcm_rst.
  - Reset asserted mid-sequence abandons the sequence immediately.
  - den/dwe drop, mmcm_rst drops.
  - No done pulse is generated.
- mmcm_locked passes through a 2-flop synchroniser; lock_s lags by 2 cycles.
- FSM states: IDLE, HOLD_RST, WAIT_ENTRY, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RELEASE, WAIT_LOCK, FINISH.
- IDLE:
  - cfg_valid=1 → HOLD_RST. The entry is not consumed.
  - Entering HOLD_RST sets mmcm_rst=1, busy=1 and clears err.
- HOLD_RST: counts RST_HOLD cycles → WAIT_ENTRY.
- WAIT_ENTRY:
  - cfg_ready=1 only in this state.
  - On cfg_valid&cfg_ready, latch addr, mask, data and last → RD_REQ.
  - cfg_valid low: wait indefinitely with mmcm_rst held.
- RD_REQ: one cycle with den=1, dwe=0, daddr=latched addr → RD_WAIT.
- RD_WAIT:
  - daddr held stable.
  - On drdy, compute new = (do_in & mask) | (data & ~mask) → WR_REQ.
- WR_REQ: one cycle with den=1, dwe=1, daddr=addr, di=new → WR_WAIT.
- WR_WAIT:
  - di and daddr held stable.
  - On drdy: last=1 → RELEASE; else → WAIT_ENTRY.
- RELEASE: mmcm_rst=0, start lock counter → WAIT_LOCK.
- WAIT_LOCK: lock_s=1 → FINISH.
- FINISH:
  - done=1 for one cycle, busy=0 → IDLE.
  - Minimum latency from last write drdy to done: RELEASE (1) + lock_s arrival + 1.
- DRDY timeout:
  - The counter restarts at each den.
  - Expiry in RD_WAIT or WR_WAIT sets err=1, releases mmcm_rst and jumps to FINISH, so done still pulses.
  - Remaining entries are not consumed.
- LOCK timeout: expiry in WAIT_LOCK sets err=1 → FINISH.
- drdy outside RD_WAIT/WR_WAIT is ignored.
- drdy arriving in the same cycle as den (in RD_REQ or WR_REQ) is ignored. The primitive never does this, so no combinational path is permitted.
- err stays 1 until the next IDLE→HOLD_RST transition.
- den is never asserted twice without an intervening drdy or timeout.
- Counters saturate and never wrap. Counter widths are $clog2 of parameter+1.

Test Plan:
- Single entry: addr=0x08, mask=0x1000, data=0x0186, read returns 0x1041, last=1.
  - Required: one read then one write to 0x08 with di=0x1186.
  - mmcm_rst high ≥16 cycles before the first den.
  - locked model asserts 50 cycles after release → done pulse exactly 3 cycles after locked rises; err=0.
- Three entries (0x08, 0x09, 0x14) with cfg_valid gaps of 10 cycles.
  - Required: six DRP accesses in order, R/W alternating.
  - cfg_ready high only in WAIT_ENTRY.
  - mmcm_rst stays high across the gaps and drops only after the third write drdy.
- DRDY timeout: model never returns drdy on the first read.
  - Required: err=1 and done pulse at DRDY_TIMEOUT+≈2 cycles after den.
  - mmcm_rst=0, cfg_ready never reasserted for the pending entries.
  - A following clean sequence clears err.
- Lock timeout: locked held 0 with LOCK_TIMEOUT overridden to 100.
  - Required: done plus err=1 at ~101 cycles after release.
- reset_n pulsed low during WR_WAIT.
  - Required: den, dwe, mmcm_rst, busy and done all 0 asynchronously; FSM in IDLE.
  - No spurious done; a fresh sequence then completes normally.
- Stray drdy pulses injected in IDLE and WAIT_ENTRY.
  - Required: no state change, no extra DRP access.
